bram_stream_reader: RTL and testbench

- Read-side client for the team's registered-output block RAM port (the addr/rden/dout port of the dual-port no-change RAM).
- Reads a contiguous run of words starting at a given address and presents them as a valid/ready stream.
- Hides the RAM read latency, including the rden-gated 3-stage pipeline.
- Absorbs consumer back-pressure with a credit-controlled output FIFO; feeds compute datapaths from on-chip buffers.

---
 rtl/bram_stream_reader_if.sv | 31 +++
 rtl/bram_stream_reader.sv | 183 ++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Purpose : signal bundle between bram_stream_reader, its job controller, the RAM read port and the stream consumer.
// Latency : none, wires only.
// Backpressure: carries m_valid/m_ready; the reader stalls on m_ready=0 through its own credit logic.
// Ports   : start/start_addr/num_words/busy/done (job control), ram_addr/ram_rden/ram_dout (RAM read port),
//           m_valid/m_data/m_ready (output stream). master = the reader, slave = its environment.
interface bram_stream_reader_if #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 10
);
    logic                    start;
    logic [C_ADDR_WIDTH-1:0] start_addr;
    logic [C_ADDR_WIDTH:0]   num_words;
    logic                    busy;
    logic                    done;
    logic [C_ADDR_WIDTH-1:0] ram_addr;
    logic                    ram_rden;
    logic [C_DATA_WIDTH-1:0] ram_dout;
    logic                    m_valid;
    logic [C_DATA_WIDTH-1:0] m_data;
    logic                    m_ready;

    modport master (
        input  start, start_addr, num_words, ram_dout, m_ready,
        output busy, done, ram_addr, ram_rden, m_valid, m_data
    );

    modport slave (
        output start, start_addr, num_words, ram_dout, m_ready,
        input  busy, done, ram_addr, ram_rden, m_valid, m_data
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Purpose : reads num_words consecutive RAM words from start_addr and streams them out on valid/ready.
// Latency : first m_valid C_RD_LATENCY+2 cycles after the start cycle, then one word per cycle.
// Backpressure: issues are credit-limited so in-flight reads plus FIFO contents never exceed C_FIFO_DEPTH.
// Ports   : clk, rst (async, active-high); bus (master modport): job control start/start_addr/num_words/
//           busy/done, RAM read port ram_addr/ram_rden/ram_dout, output stream m_valid/m_data/m_ready.
// C_FIFO_DEPTH must be a power of 2 and >= C_RD_LATENCY+1; full rate needs >= C_RD_LATENCY+2.
module bram_stream_reader #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 10,
    parameter int C_RD_LATENCY = 1,
    parameter int C_FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    bram_stream_reader_if.master bus
);
    localparam int PW  = $clog2(C_FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [C_RD_LATENCY-1:0] tag_q, tag_d, tag_shift;
    logic                    zero_done_q, zero_done_d;
    logic [C_DATA_WIDTH-1:0] mem_q [C_FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           inflight;
    logic [CW:0]             credit_used;

    logic rden, busy, issue, push, pop, fifo_vld, final_pop;

    // Each tag bit marks a read that is still inside the RAM pipeline; the
    // oldest bit lines up with the cycle its data sits on ram_dout.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < C_RD_LATENCY; i++) begin
            inflight = inflight + CW'(tag_q[i]);
        end
    end

    generate
        if (C_RD_LATENCY == 1) begin : g_tag_single
            assign tag_shift = issue;
        end else begin : g_tag_multi
            assign tag_shift = {tag_q[C_RD_LATENCY-2:0], issue};
        end
    endgenerate

    // Credit check uses the registered count only; a pop in the same cycle is
    // not credited, which costs nothing in safety and keeps the path short.
    assign credit_used = {1'b0, count_q} + {1'b0, inflight};
    assign issue       = (state_q == S_ISSUE) && (remaining_q != '0)
                         && (credit_used < CW1'(C_FIFO_DEPTH));
    assign push        = rden && tag_q[C_RD_LATENCY-1];
    assign fifo_vld    = (count_q != '0);
    assign pop         = fifo_vld && bus.m_ready;
    assign final_pop   = (state_q == S_DRAIN) && pop && (remaining_q == '0)
                         && (inflight == '0) && (count_q == CW'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.num_words != '0)) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue && (remaining_q == (C_ADDR_WIDTH+1)'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (final_pop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // rden stays high for the whole job so the RAM's rden-gated output stages
    // keep advancing and data appears a fixed C_RD_LATENCY cycles after issue.
    always_comb begin
        rden = 1'b0;
        busy = 1'b0;
        case (state_q)
            S_ISSUE, S_DRAIN: begin
                rden = 1'b1;
                busy = 1'b1;
            end
            default: begin
                rden = 1'b0;
                busy = 1'b0;
            end
        endcase
        bus.busy     = busy;
        bus.ram_rden = rden;
        bus.ram_addr = addr_q;
        bus.done     = zero_done_q || final_pop;
        bus.m_valid  = fifo_vld;
        // Gated so the stream bus reads zero whenever nothing is presented.
        bus.m_data   = fifo_vld ? mem_q[rd_ptr_q] : '0;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        zero_done_d = 1'b0;
        tag_d       = rden ? tag_shift : tag_q;
        count_d     = count_q;

        if ((state_q == S_IDLE) && bus.start) begin
            if (bus.num_words != '0) begin
                addr_d      = bus.start_addr;
                remaining_d = bus.num_words;
            end else begin
                zero_done_d = 1'b1;
            end
        end else if (issue) begin
            // Address wraps naturally at the top of the RAM.
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            tag_q       <= '0;
            zero_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            tag_q       <= tag_d;
            zero_done_q <= zero_done_d;
            count_q     <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.ram_dout;
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Purpose : checks two reader instances (A: L=1, 16-word RAM, depth 4; B: L=3, 64-word RAM, depth 8)
//           against a queue model of "word i of a job = RAM[(addr+i) mod size]".
// Latency : first-word latency, rden duration, done timing and credit stalls checked alongside data.
// Backpressure: m_ready driven held-high, held-low or random.
module tb_bram_stream_reader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start      = 1'b0;
    logic [5:0] start_addr = '0;
    logic [6:0] num_words  = '0;
    logic       m_ready    = 1'b0;
    int         ready_mode = 0;   // 0: low, 1: high, 2: random
    bit         allow_bare_done = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int rden_a = 0, rden_b = 0, hs_a = 0, hs_b = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } exp_t;

    exp_t exp_qa[$];
    exp_t exp_qb[$];
    exp_t ea, eb;

    bram_stream_reader_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(4)) if_a ();
    bram_stream_reader_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(6)) if_b ();

    bram_stream_reader #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(4), .C_RD_LATENCY(1), .C_FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    bram_stream_reader #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(6), .C_RD_LATENCY(3), .C_FIFO_DEPTH(8))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));

    function automatic logic [31:0] ram_word(input int unsigned a);
        return 32'hA500_0000 + 32'(a) + 32'd100;
    endfunction

    // RAM models: registered output, every stage advances only while rden=1.
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        if (if_a.ram_rden) pipe_a <= ram_word(32'(if_a.ram_addr));
        if (if_b.ram_rden) begin
            pipe_b[0] <= ram_word(32'(if_b.ram_addr));
            pipe_b[1] <= pipe_b[0];
            pipe_b[2] <= pipe_b[1];
        end
    end

    assign if_a.start      = start;
    assign if_a.start_addr = start_addr[3:0];
    assign if_a.num_words  = num_words[4:0];
    assign if_a.m_ready    = m_ready;
    assign if_a.ram_dout   = pipe_a;
    assign if_b.start      = start;
    assign if_b.start_addr = start_addr;
    assign if_b.num_words  = num_words;
    assign if_b.m_ready    = m_ready;
    assign if_b.ram_dout   = pipe_b[2];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ready driver: the only writer of m_ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitors: pop the expected word on every handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_a.ram_rden) rden_a++;
                if (if_a.m_valid && if_a.m_ready) begin
                    hs_a++;
                    if (exp_qa.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL A_extra_word: got %0h expected no word", if_a.m_data);
                    end else begin
                        ea = exp_qa.pop_front();
                        check("A_data", 64'(if_a.m_data), 64'(ea.d));
                        check("A_done_at_last", 64'(if_a.done), 64'(ea.last));
                    end
                end else if (if_a.done && !allow_bare_done) begin
                    n_vec++; n_err++;
                    $display("FAIL A_bare_done: got 1 expected 0");
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_b.ram_rden) rden_b++;
                if (if_b.m_valid && if_b.m_ready) begin
                    hs_b++;
                    if (exp_qb.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL B_extra_word: got %0h expected no word", if_b.m_data);
                    end else begin
                        eb = exp_qb.pop_front();
                        check("B_data", 64'(if_b.m_data), 64'(eb.d));
                        check("B_done_at_last", 64'(if_b.done), 64'(eb.last));
                    end
                end else if (if_b.done && !allow_bare_done) begin
                    n_vec++; n_err++;
                    $display("FAIL B_bare_done: got 1 expected 0");
                end
            end
        end
    end

    task automatic push_job(input int addr, input int num);
        for (int i = 0; i < num; i++) begin
            exp_qa.push_back('{d: ram_word((addr + i) % 16), last: (i == num - 1)});
            exp_qb.push_back('{d: ram_word((addr + i) % 64), last: (i == num - 1)});
        end
    endtask

    // Returns one cycle after the start cycle, at posedge+1.
    task automatic start_pulse(input int addr, input int num, input bit model);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 6'(addr);
        num_words  = 7'(num);
        if (model) push_job(addr, num);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_qa.size() == 0 && exp_qb.size() == 0 && !if_a.busy && !if_b.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got busy/pending expected idle within 3000 cycles", nm);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_A_busy"}, 64'(if_a.busy), 0);
        check({nm, "_A_done"}, 64'(if_a.done), 0);
        check({nm, "_A_rden"}, 64'(if_a.ram_rden), 0);
        check({nm, "_A_valid"}, 64'(if_a.m_valid), 0);
        check({nm, "_A_addr"}, 64'(if_a.ram_addr), 0);
        check({nm, "_A_data"}, 64'(if_a.m_data), 0);
        check({nm, "_B_busy"}, 64'(if_b.busy), 0);
        check({nm, "_B_done"}, 64'(if_b.done), 0);
        check({nm, "_B_rden"}, 64'(if_b.ram_rden), 0);
        check({nm, "_B_valid"}, 64'(if_b.m_valid), 0);
        check({nm, "_B_addr"}, 64'(if_b.ram_addr), 0);
        check({nm, "_B_data"}, 64'(if_b.m_data), 0);
    endtask

    // Full-rate job: first-valid latency L+2; rden spans issue + pipeline + final FIFO cycle.
    task automatic measured_job(input int addr, input int num);
        int lat_a, lat_b;
        lat_a = -1;
        lat_b = -1;
        rden_a = 0;
        rden_b = 0;
        start_pulse(addr, num, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (if_a.m_valid && lat_a < 0) lat_a = k;
            if (if_b.m_valid && lat_b < 0) lat_b = k;
            if (lat_a >= 0 && lat_b >= 0) break;
        end
        check("A_first_valid_latency", 64'(lat_a), 64'(3));
        check("B_first_valid_latency", 64'(lat_b), 64'(5));
        wait_idle("measured");
        check("A_rden_cycles", 64'(rden_a), 64'(num + 2));
        check("B_rden_cycles", 64'(rden_b), 64'(num + 4));
    endtask

    initial begin
        int base;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 1;
        repeat (2) @(posedge clk);

        measured_job(5, 3);
        measured_job(0, 8);

        // Wrap: A reads 14,15,0,1; B reads 62,63,0,1.
        start_pulse(62, 4, 1'b1);
        wait_idle("wrap");

        // Back-pressure: issue stops once FIFO + in-flight reach the depth.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        start_pulse(33, 10, 1'b1);
        repeat (20) @(negedge clk);
        check("A_stall_ram_addr", 64'(if_a.ram_addr), 64'((33 + 4) % 16));
        check("B_stall_ram_addr", 64'(if_b.ram_addr), 64'((33 + 8) % 64));
        check("A_stall_valid", 64'(if_a.m_valid), 1);
        check("A_stall_data_held", 64'(if_a.m_data), 64'(ram_word(33 % 16)));
        check("B_stall_data_held", 64'(if_b.m_data), 64'(ram_word(33)));
        ready_mode = 1;
        wait_idle("backpressure");

        // Zero-length job.
        allow_bare_done = 1'b1;
        start_pulse(3, 0, 1'b1);
        @(negedge clk);
        check("A_zero_done", 64'(if_a.done), 1);
        check("B_zero_done", 64'(if_b.done), 1);
        check("A_zero_busy", 64'(if_a.busy), 0);
        check("B_zero_rden", 64'(if_b.ram_rden), 0);
        @(negedge clk);
        check("A_zero_done_once", 64'(if_a.done), 0);
        check("B_zero_done_once", 64'(if_b.done), 0);
        allow_bare_done = 1'b0;

        // Start while busy must be ignored.
        start_pulse(10, 5, 1'b1);
        @(posedge clk);
        #1;
        check("A_busy_mid_job", 64'(if_a.busy), 1);
        check("B_busy_mid_job", 64'(if_b.busy), 1);
        start = 1'b1;
        start_addr = 6'd50;
        num_words = 7'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("start_while_busy");

        // Reset after two of six words on A.
        base = hs_a;
        start_pulse(40, 6, 1'b1);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (hs_a - base >= 2) break;
        end
        rst = 1'b1;
        #1 check_all_zero("midjob_reset");
        exp_qa.delete();
        exp_qb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        start_pulse(20, 2, 1'b1);
        wait_idle("after_reset");

        // Random jobs under random back-pressure.
        ready_mode = 2;
        for (int j = 0; j < 25; j++) begin
            start_pulse($urandom_range(0, 63), $urandom_range(1, 12), 1'b1);
            wait_idle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1, "watchdog");
    end
endmodule
